// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the enemy controllers.
//   slime_state_t : 2-bit slime controller state.
//   X_W / Y_W     : screen coordinate widths.
//   TICK_W        : width of per-state tick timers.
package game_pkg;

    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int TICK_W = 8;

    typedef enum logic [1:0] {
        S_WALK    = 2'd0,
        S_FROZEN  = 2'd1,
        S_SHATTER = 2'd2,
        S_DEAD    = 2'd3
    } slime_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..DIV-1 counter producing a one-cycle tick.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear; the count restarts at 0 on the next edge
//   tick  : high on the cycle the count equals DIV-1
module tick_prescaler #(
    parameter int unsigned DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/slime_ctrl.sv
// slime_ctrl: one slime enemy - patrol, freeze, shatter and respawn.
//   clk, rst_n : clock, asynchronous active-low reset
//   hit_ice    : one-cycle pulse, player's ice hit the slime
//   broken     : level from the break detector
//   x_slim     : slime x (registered)
//   y_slim     : slime y, constant Y_POS
//   isfrozen   : high in FROZEN
//   alive      : high in WALK and FROZEN
//   dir        : 1 = moving right, 0 = moving left
//   shatter    : high in SHATTER
//   kill_pulse : one cycle on entering SHATTER
module slime_ctrl
    import game_pkg::*;
#(
    parameter logic [X_W-1:0]    X_MIN         = 10'd100,
    parameter logic [X_W-1:0]    X_MAX         = 10'd500,
    parameter logic [X_W-1:0]    X_START       = 10'd100,
    parameter logic [Y_W-1:0]    Y_POS         = 9'd300,
    parameter logic [X_W-1:0]    STEP          = 10'd2,
    parameter logic [19:0]       MOVE_DIV      = 20'd500000,
    parameter logic [TICK_W-1:0] FREEZE_TICKS  = 8'd150,
    parameter logic [TICK_W-1:0] SHATTER_TICKS = 8'd25,
    parameter logic [TICK_W-1:0] RESPAWN_TICKS = 8'd100
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           hit_ice,
    input  logic           broken,
    output logic [X_W-1:0] x_slim,
    output logic [Y_W-1:0] y_slim,
    output logic           isfrozen,
    output logic           alive,
    output logic           dir,
    output logic           shatter,
    output logic           kill_pulse
);

    slime_state_t      state_reg, state_next;
    logic [X_W-1:0]    x_reg, x_next;
    logic              dir_reg, dir_next;
    logic [TICK_W-1:0] timer_reg, timer_next;
    logic [TICK_W-1:0] timer_inc;
    logic              isfrozen_reg, alive_reg, shatter_reg, kill_reg;
    logic              tick;
    logic              clr;

    // One extra bit so x+STEP near the top of the range cannot wrap.
    logic [X_W:0] x_plus;
    logic [X_W:0] left_limit;

    assign x_plus     = {1'b0, x_reg} + {1'b0, STEP};
    assign left_limit = {1'b0, X_MIN} + {1'b0, STEP};
    assign timer_inc  = timer_reg + 1'b1;

    tick_prescaler #(
        .DIV (32'(MOVE_DIV))
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        dir_next   = dir_reg;
        timer_next = timer_reg;
        clr        = 1'b0;

        case (state_reg)
            S_WALK: begin
                if (broken) begin
                    state_next = S_SHATTER;
                end else if (hit_ice) begin
                    state_next = S_FROZEN;
                end else if (tick) begin
                    if (dir_reg) begin
                        if (x_plus >= {1'b0, X_MAX}) begin
                            x_next   = X_MAX;
                            dir_next = 1'b0;
                        end else begin
                            x_next = x_plus[X_W-1:0];
                        end
                    end else begin
                        if ({1'b0, x_reg} <= left_limit) begin
                            x_next   = X_MIN;
                            dir_next = 1'b1;
                        end else begin
                            x_next = x_reg - STEP;
                        end
                    end
                end
            end
            S_FROZEN: begin
                if (broken) begin
                    state_next = S_SHATTER;
                end else if (hit_ice) begin
                    // Re-hit restarts the whole freeze period.
                    timer_next = '0;
                    clr        = 1'b1;
                end else if (tick) begin
                    if (timer_inc == FREEZE_TICKS) state_next = S_WALK;
                    else                           timer_next = timer_inc;
                end
            end
            S_SHATTER: begin
                if (tick) begin
                    if (timer_inc == SHATTER_TICKS) state_next = S_DEAD;
                    else                            timer_next = timer_inc;
                end
            end
            default: begin // S_DEAD
                if (tick) begin
                    if (timer_inc == RESPAWN_TICKS) begin
                        state_next = S_WALK;
                        x_next     = X_START;
                        dir_next   = 1'b1;
                    end else begin
                        timer_next = timer_inc;
                    end
                end
            end
        endcase

        // Every state change restarts both the tick phase and the timer.
        if (state_next != state_reg) begin
            timer_next = '0;
            clr        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_WALK;
            x_reg        <= X_START;
            dir_reg      <= 1'b1;
            timer_reg    <= '0;
            isfrozen_reg <= 1'b0;
            alive_reg    <= 1'b1;
            shatter_reg  <= 1'b0;
            kill_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            dir_reg      <= dir_next;
            timer_reg    <= timer_next;
            // Flags are decoded from the next state so they change on the
            // same edge as the state itself.
            isfrozen_reg <= (state_next == S_FROZEN);
            alive_reg    <= (state_next == S_WALK) || (state_next == S_FROZEN);
            shatter_reg  <= (state_next == S_SHATTER);
            kill_reg     <= (state_next == S_SHATTER) && (state_reg != S_SHATTER);
        end
    end

    assign x_slim     = x_reg;
    assign y_slim     = Y_POS;
    assign isfrozen   = isfrozen_reg;
    assign alive      = alive_reg;
    assign dir        = dir_reg;
    assign shatter    = shatter_reg;
    assign kill_pulse = kill_reg;

endmodule

// File: tb/tb_slime_ctrl.sv
// tb_slime_ctrl: scoreboard bench for slime_ctrl with a cycle-age reference model.
module tb_slime_ctrl;

    localparam int DIV  = 4;
    localparam int STP  = 2;
    localparam int XMIN = 100;
    localparam int XMAX = 110;
    localparam int XST  = 100;
    localparam int YP   = 300;
    localparam int FT   = 3;
    localparam int ST   = 2;
    localparam int RT   = 3;

    localparam int MW = 0, MF = 1, MS = 2, MD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hit_ice = 1'b0;
    logic       broken = 1'b0;
    logic [9:0] x_slim;
    logic [8:0] y_slim;
    logic       isfrozen, alive, dir, shatter, kill_pulse;

    slime_ctrl #(
        .X_MIN(10'(XMIN)), .X_MAX(10'(XMAX)), .X_START(10'(XST)), .Y_POS(9'(YP)),
        .STEP(10'(STP)), .MOVE_DIV(20'(DIV)), .FREEZE_TICKS(8'(FT)),
        .SHATTER_TICKS(8'(ST)), .RESPAWN_TICKS(8'(RT))
    ) dut (
        .clk(clk), .rst_n(rst_n), .hit_ice(hit_ice), .broken(broken),
        .x_slim(x_slim), .y_slim(y_slim), .isfrozen(isfrozen), .alive(alive),
        .dir(dir), .shatter(shatter), .kill_pulse(kill_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       frz;
        logic       alv;
        logic       dr;
        logic       sh;
        logic       kl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: the slime's mode plus the number of cycles since the
    // tick phase last restarted. A tick lands on every DIV-th cycle of that
    // age; a phase lasting N ticks ends on its (N*DIV)-th cycle.
    int m_state, m_age, m_x;
    bit m_dir, m_kill;

    function automatic void model_reset();
        m_state = MW; m_age = 0; m_x = XST; m_dir = 1'b1; m_kill = 1'b0;
    endfunction

    function automatic void model_step(input bit h, input bit b);
        int prev    = m_state;
        bit restart = 1'b0;
        bit tick    = ((m_age + 1) % DIV) == 0;
        m_kill = 1'b0;
        case (m_state)
            MW: begin
                if (b) begin m_state = MS; m_kill = 1'b1; end
                else if (h) m_state = MF;
                else if (tick) begin
                    if (m_dir) begin
                        if (m_x + STP >= XMAX) begin m_x = XMAX; m_dir = 1'b0; end
                        else m_x = m_x + STP;
                    end else begin
                        if (m_x <= XMIN + STP) begin m_x = XMIN; m_dir = 1'b1; end
                        else m_x = m_x - STP;
                    end
                end
            end
            MF: begin
                if (b) begin m_state = MS; m_kill = 1'b1; end
                else if (h) restart = 1'b1;
                else if (m_age + 1 == FT * DIV) m_state = MW;
            end
            MS: if (m_age + 1 == ST * DIV) m_state = MD;
            default: if (m_age + 1 == RT * DIV) begin
                m_state = MW; m_x = XST; m_dir = 1'b1;
            end
        endcase
        if (m_state != prev || restart) m_age = 0;
        else m_age = m_age + 1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.x   = 10'(m_x);
        e.y   = 9'(YP);
        e.frz = (m_state == MF);
        e.alv = (m_state == MW) || (m_state == MF);
        e.dr  = m_dir;
        e.sh  = (m_state == MS);
        e.kl  = m_kill;
        return e;
    endfunction

    // Called at a falling edge: drive inputs for the next rising edge,
    // queue the model's prediction for it, then move to the next falling edge.
    task automatic cycle(input bit h, input bit b);
        hit_ice = h;
        broken  = b;
        model_step(h, b);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"}, int'(x_slim), XST);
        check({tag, "_y"}, int'(y_slim), YP);
        check({tag, "_isfrozen"}, int'(isfrozen), 0);
        check({tag, "_alive"}, int'(alive), 1);
        check({tag, "_dir"}, int'(dir), 1);
        check({tag, "_shatter"}, int'(shatter), 0);
        check({tag, "_kill"}, int'(kill_pulse), 0);
    endtask

    // Monitor: one scoreboard entry per clocked cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_x", int'(x_slim), int'(e.x));
            check("sb_y", int'(y_slim), int'(e.y));
            check("sb_isfrozen", int'(isfrozen), int'(e.frz));
            check("sb_alive", int'(alive), int'(e.alv));
            check("sb_dir", int'(dir), int'(e.dr));
            check("sb_shatter", int'(shatter), int'(e.sh));
            check("sb_kill", int'(kill_pulse), int'(e.kl));
        end
    end

    initial begin
        int burst;
        bit h, b;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        model_reset();

        // Patrol
        repeat (4)  cycle(0, 0);
        check("patrol_x4", int'(x_slim), 102);
        repeat (16) cycle(0, 0);
        check("patrol_x20", int'(x_slim), 110);
        check("patrol_dir20", int'(dir), 0);
        repeat (4)  cycle(0, 0);
        check("patrol_x24", int'(x_slim), 108);
        repeat (16) cycle(0, 0);
        check("patrol_x40", int'(x_slim), 100);
        check("patrol_dir40", int'(dir), 1);

        // Freeze at x=104
        repeat (8) cycle(0, 0);
        check("freeze_pre_x", int'(x_slim), 104);
        cycle(1, 0);
        check("freeze_isfrozen", int'(isfrozen), 1);
        repeat (11) cycle(0, 0);
        check("freeze_hold_frz", int'(isfrozen), 1);
        check("freeze_hold_x", int'(x_slim), 104);
        cycle(0, 0);
        check("freeze_end_frz", int'(isfrozen), 0);
        repeat (4) cycle(0, 0);
        check("freeze_resume_x", int'(x_slim), 106);

        // Refreeze 8 cycles in: 20 cycles frozen in total
        cycle(1, 0);
        repeat (7) cycle(0, 0);
        cycle(1, 0);
        repeat (11) cycle(0, 0);
        check("refreeze_still", int'(isfrozen), 1);
        cycle(0, 0);
        check("refreeze_end", int'(isfrozen), 0);

        // Break while frozen, broken held 5 cycles
        cycle(1, 0);
        repeat (2) cycle(0, 0);
        cycle(0, 1);
        check("break_kill", int'(kill_pulse), 1);
        check("break_alive", int'(alive), 0);
        check("break_shatter", int'(shatter), 1);
        repeat (4) cycle(0, 1);
        check("break_kill_once", int'(kill_pulse), 0);
        repeat (3) cycle(0, 0);
        check("shatter_last", int'(shatter), 1);
        cycle(0, 0);
        check("dead_shatter", int'(shatter), 0);
        check("dead_alive", int'(alive), 0);
        repeat (11) cycle(0, 0);
        check("dead_last", int'(alive), 0);
        cycle(0, 0);
        check("respawn_alive", int'(alive), 1);
        check("respawn_x", int'(x_slim), XST);
        check("respawn_dir", int'(dir), 1);

        // Priority: broken and hit_ice together in WALK
        cycle(1, 1);
        check("prio_shatter", int'(shatter), 1);
        check("prio_isfrozen", int'(isfrozen), 0);
        check("prio_kill", int'(kill_pulse), 1);

        // Asynchronous reset mid-SHATTER, between clock edges
        repeat (2) cycle(0, 0);
        hit_ice = 1'b0;
        broken  = 1'b0;
        model_step(0, 0);
        exp_q.push_back(model_out());
        @(posedge clk);
        #3;
        check("async_pre_shatter", int'(shatter), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            h = ($urandom_range(0, 19) == 0);
            if (burst > 0) begin
                b = 1'b1;
                burst--;
            end else if ($urandom_range(0, 59) == 0) begin
                b = 1'b1;
                burst = int'($urandom_range(0, 4));
            end else begin
                b = 1'b0;
            end
            cycle(h, b);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
